// File: rtl/axis_packetizer.sv
// Frames an unframed sample stream into packets of pkt_len beats and tags tlast on the
// final beat; define AXIS_PACKETIZER_CHECKSUM_EN to append a modulo-2^data_width sum beat.
// Latency 1 cycle into an empty buffer; two-entry registered skid buffer gives full rate.
module axis_packetizer #(
  parameter int data_width = 16,
  parameter int len_width  = 12,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  tvalid_in,
  output logic                  tready_out,
  input  logic [len_width-1:0]  pkt_len,
  output logic [data_width-1:0] data_out,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  input  logic                  tready_in,
  output logic [cnt_width-1:0]  pkt_count,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
  localparam logic [1:0] CSUM   = 2'd2;
`endif
  localparam logic [len_width-1:0] LEN_ONE = 1;
  localparam logic [cnt_width-1:0] CNT_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [len_width-1:0]  len_q, len_d;
  logic [len_width-1:0]  beat_q, beat_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;
  logic [data_width-1:0] out_dat_q, out_dat_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  skid_last_q, skid_last_d;
  logic [data_width-1:0] skid_dat_q, skid_dat_d;
  logic                  rdy_q, rdy_d;
  logic [cnt_width-1:0]  pkt_count_q, pkt_count_d;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
  logic [data_width-1:0] sum_q, sum_d;
`endif

  logic                  in_xfer;
  logic                  pop;
  logic                  push;
  logic                  push_last;
  logic [data_width-1:0] push_dat;
  logic                  is_last;
  logic [len_width-1:0]  len_eff;

`ifdef AXIS_PACKETIZER_CHECKSUM_EN
  // Source is held off while the checksum beat waits for buffer space.
  assign tready_out = rdy_q && (state_q != CSUM);
`else
  assign tready_out = rdy_q;
`endif
  assign in_xfer = tvalid_in && tready_out;
  assign pop     = out_vld_q && tready_in;
  assign len_eff = (pkt_len == '0) ? LEN_ONE : pkt_len;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_dat  = data_in;
    is_last   = 1'b0;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          push   = 1'b1;
          len_d  = len_eff;
          beat_d = LEN_ONE;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
          sum_d  = data_in;
`endif
          if (len_eff == LEN_ONE) begin
            is_last = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (in_xfer) begin
          push   = 1'b1;
          beat_d = beat_q + LEN_ONE;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
          sum_d  = sum_q + data_in;
`endif
          is_last = (beat_d == len_q);
        end
      end
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      CSUM: begin
        if (rdy_q) begin
          push      = 1'b1;
          push_dat  = sum_q;
          push_last = 1'b1;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (is_last) begin
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      state_d   = CSUM;
`else
      state_d   = IDLE;
      push_last = 1'b1;
`endif
    end
  end

  // A push only ever happens while the skid entry is empty (rdy_q).
  always_comb begin
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_dat_d   = out_dat_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_dat_d  = skid_dat_q;
    pkt_count_d = pkt_count_q;
    if (skid_vld_q) begin
      if (pop) begin
        out_dat_d  = skid_dat_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end
    end else if (!out_vld_q || pop) begin
      out_vld_d  = push;
      out_last_d = push && push_last;
      if (push) begin
        out_dat_d = push_dat;
      end
    end else if (push) begin
      skid_vld_d  = 1'b1;
      skid_last_d = push_last;
      skid_dat_d  = push_dat;
    end
    rdy_d = !skid_vld_d;
    if (pop && out_last_q) begin
      pkt_count_d = pkt_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_dat_q   <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_dat_q  <= '0;
      rdy_q       <= 1'b0;
      pkt_count_q <= '0;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_dat_q   <= out_dat_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_dat_q  <= skid_dat_d;
      rdy_q       <= rdy_d;
      pkt_count_q <= pkt_count_d;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign data_out   = out_dat_q;
  assign tvalid_out = out_vld_q;
  assign tlast_out  = out_last_q;
  assign pkt_count  = pkt_count_q;
  assign busy       = (state_q != IDLE) || out_vld_q || skid_vld_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer with a scoreboard of expected output beats.
module tb_axis_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        tvalid_in = 1'b0;
  logic        tready_out;
  logic [11:0] pkt_len = 12'd4;
  logic [15:0] data_out;
  logic        tvalid_out;
  logic        tlast_out;
  logic        tready_in = 1'b1;
  logic [3:0]  pkt_count;
  logic        busy;

  axis_packetizer #(.data_width(16), .len_width(12), .cnt_width(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .tvalid_in(tvalid_in),
    .tready_out(tready_out), .pkt_len(pkt_len), .data_out(data_out),
    .tvalid_out(tvalid_out), .tlast_out(tlast_out), .tready_in(tready_in),
    .pkt_count(pkt_count), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          m_idle = 1;
  int          m_len = 0;
  int          m_cnt = 0;
  logic [15:0] m_sum = '0;
  logic [3:0]  m_pkts = '0;
  bit          prev_stall = 0;
  logic [15:0] prev_dat = '0;
  logic        prev_last = 0;
  bit          csum_chk = 0;
  int          obs_last = 0;
  int          obs_beats = 0;
  logic [15:0] last_out_dat = '0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready pattern: 0 always-ready, 1 toggle, 2 held low, 3 five-cycle stall then toggle.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: tready_in = 1'b1;
      1: tready_in = ~tready_in;
      2: tready_in = 1'b0;
      default: begin
        tready_in = 1'b0;
        stall_cnt++;
        if (stall_cnt >= 5) begin
          stall_cnt = 0;
          rdy_mode  = 1;
        end
      end
    endcase
  end

  // Monitor and reference model, sampled on the falling edge.
  initial forever begin
    beat_t e;
    bit    lst;
    @(negedge clk);
    if (mon_en && reset) begin
      chk("pkt_count", pkt_count, m_pkts);
      if (prev_stall) begin
        chk("hold_vld", tvalid_out, 1'b1);
        chk("hold_dat", data_out, prev_dat);
        chk("hold_last", tlast_out, prev_last);
      end
`ifndef AXIS_PACKETIZER_CHECKSUM_EN
      chk("occ_vld", tvalid_out, sb.size() != 0);
      chk("occ_rdy", tready_out, sb.size() < 2);
`else
      if (csum_chk) chk("csum_rdy", tready_out, 1'b0);
      csum_chk = 0;
`endif
      if (tvalid_out && tready_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("out_dat", data_out, e.d);
          chk("out_last", tlast_out, e.l);
          if (e.l) m_pkts = m_pkts + 4'd1;
        end
        obs_beats++;
        if (tlast_out) obs_last++;
        last_out_dat = data_out;
      end
      prev_stall = tvalid_out && !tready_in;
      prev_dat   = data_out;
      prev_last  = tlast_out;
      if (tvalid_in && tready_out) begin
        if (m_idle) begin
          m_len  = (pkt_len == 0) ? 1 : int'(pkt_len);
          m_cnt  = 1;
          m_sum  = data_in;
          m_idle = 0;
        end else begin
          m_cnt++;
          m_sum = m_sum + data_in;
        end
        lst = (m_cnt == m_len);
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
        e.d = data_in; e.l = 1'b0; sb.push_back(e);
        if (lst) begin
          e.d = m_sum; e.l = 1'b1; sb.push_back(e);
          csum_chk = 1;
        end
`else
        e.d = data_in; e.l = lst; sb.push_back(e);
`endif
        if (lst) m_idle = 1;
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send(input logic [15:0] d);
    bit ok;
    int tries;
    ok = 0;
    tries = 0;
    tvalid_in = 1'b1;
    data_in = d;
    while (!ok && tries < 100) begin
      @(negedge clk);
      ok = tready_out;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!ok) chk("send_timeout", ok, 1'b1);
    tvalid_in = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    tvalid_in = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !tvalid_out && !busy;
    end
    if (!done) chk("drain_timeout", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   l0;
    int   b0;
    longint t0;
    #2 reset = 1'b0;
    #1;
    chk("rst_vld", tvalid_out, 1'b0);
    chk("rst_last", tlast_out, 1'b0);
    chk("rst_dat", data_out, 16'h0);
    chk("rst_cnt", pkt_count, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", tready_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", tready_out, 1'b1);
    mon_en = 1;

    // Basic framing at full rate.
    pkt_len = 12'd4;
    rdy_mode = 0;
    l0 = obs_last;
    t0 = $time;
    for (int i = 1; i <= 8; i++) send(16'(i));
    chk("full_rate", 32'($time - t0), 32'd80);
    drain();
    chk("basic_pkts", pkt_count, 4'd2);
    chk("basic_lasts", obs_last - l0, 2);

    // Backpressure: toggling ready plus a five-cycle stall.
    pkt_len = 12'd3;
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i));
    rdy_mode = 3;
    for (int i = 6; i < 12; i++) send(16'h0100 + 16'(i));
    drain();

    // Length edges.
    l0 = obs_last;
    pkt_len = 12'd0;
    for (int i = 0; i < 3; i++) send(16'h0200 + 16'(i));
    pkt_len = 12'd1;
    for (int i = 3; i < 6; i++) send(16'h0200 + 16'(i));
    drain();
    chk("len01_lasts", obs_last - l0, 6);
    l0 = obs_last;
    pkt_len = 12'd5;
    send(16'h0300);
    pkt_len = 12'd2;
    for (int i = 1; i < 7; i++) send(16'h0300 + 16'(i));
    drain();
    chk("len_change_lasts", obs_last - l0, 2);

    // Reset mid-packet with the buffer full.
    pkt_len = 12'd3;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(16'h0A01);
    send(16'h0A02);
    tvalid_in = 1'b1;
    data_in = 16'h0A03;
    @(negedge clk);
    #1;
    chk("busy_full", busy, 1'b1);
    chk("rdy_full", tready_out, 1'b0);
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk("mid_rst_vld", tvalid_out, 1'b0);
    chk("mid_rst_last", tlast_out, 1'b0);
    chk("mid_rst_cnt", pkt_count, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    sb.delete();
    m_idle = 1;
    m_pkts = '0;
    tvalid_in = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Wrap of the 4-bit packet counter, starting clean after reset.
    pkt_len = 12'd1;
    for (int i = 0; i < 17; i++) send(16'h0400 + 16'(i));
    drain();
    chk("wrap_cnt", pkt_count, 4'h1);

`ifdef AXIS_PACKETIZER_CHECKSUM_EN
    l0 = obs_last;
    b0 = obs_beats;
    pkt_len = 12'd3;
    send(16'hFFFF);
    send(16'h0002);
    send(16'h0010);
    drain();
    chk("csum_beats", obs_beats - b0, 4);
    chk("csum_lasts", obs_last - l0, 1);
    chk("csum_word", last_out_dat, 16'h0011);
`else
    b0 = obs_beats;
    pkt_len = 12'd3;
    send(16'hFFFF);
    send(16'h0002);
    send(16'h0010);
    drain();
    chk("plain_beats", obs_beats - b0, 3);
    chk("plain_word", last_out_dat, 16'h0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
